// File: rtl/upd_slow_phy_to_llr_pkg.sv
// Shared constants and FSM state type for the slow-PHY to LLR unpacker.
package upd_slow_phy_to_llr_pkg;

   localparam int SAMPLE_W   = 16;
   localparam int LANES      = 8;
   localparam int WORD_W     = SAMPLE_W * LANES;
   localparam int LANE_IDX_W = $clog2(LANES);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH
   } state_t;

endpackage

// File: rtl/upd_slow_phy_to_llr_lane_mux.sv
// Selects one SAMPLE_W-wide lane out of a packed FIFO word.
module upd_slow_lane_mux
   import upd_slow_phy_to_llr_pkg::*;
(
   input  logic [WORD_W-1:0]     word,
   input  logic [LANE_IDX_W-1:0] sel,
   output logic [SAMPLE_W-1:0]   lane
);

   assign lane = word[SAMPLE_W*int'(sel) +: SAMPLE_W];

endmodule

// File: rtl/upd_slow_phy_to_llr.sv
// Unpacks IQ and noise FIFO words into a two-RE-per-beat stream with the matching noise value.
module upd_slow_phy_to_llr
   import upd_slow_phy_to_llr_pkg::*;
(
   input  logic                i_core_clk,
   input  logic                i_rx_rst,
   input  logic [15:0]         i_user_iq_noise_rate,
   input  logic [15:0]         i_cur_user_re_amounts,
   input  logic [WORD_W-1:0]   IQ_Data_SUM,
   input  logic [WORD_W-1:0]   Noise_Data_SUM,
   input  logic                IQ_FIFO_Empty,
   input  logic                Noise_FIFO_Empty,
   output logic                IQ_FIFO_Read_Enable,
   output logic                Noise_FIFO_Read_Enable,
   output logic                o_data_strobe,
   output logic [SAMPLE_W-1:0] o_re0_data_i,
   output logic [SAMPLE_W-1:0] o_re0_data_q,
   output logic [SAMPLE_W-1:0] o_re1_data_i,
   output logic [SAMPLE_W-1:0] o_re1_data_q,
   output logic [SAMPLE_W-1:0] o_noise_data
);

   state_t                state;
   state_t                state_next;
   logic [15:0]           rate;
   logic [15:0]           amount;
   logic [15:0]           re_cnt;
   logic [15:0]           nre;
   logic                  half;
   logic [LANE_IDX_W-1:0] nlane;

   logic                  fire;
   logic                  last_beat;
   logic                  nre_wrap;
   logic [16:0]           re_cnt_sum;
   logic [15:0]           nre_sum;

   logic [SAMPLE_W-1:0]   re0_i;
   logic [SAMPLE_W-1:0]   re0_q;
   logic [SAMPLE_W-1:0]   re1_i;
   logic [SAMPLE_W-1:0]   re1_q;
   logic [SAMPLE_W-1:0]   noise;

   // Reset gates fire so no FIFO word is lost while a user is being abandoned.
   assign fire       = (state == ST_RUN) && !IQ_FIFO_Empty && !Noise_FIFO_Empty && !i_rx_rst;
   assign re_cnt_sum = {1'b0, re_cnt} + 17'd2;
   assign last_beat  = re_cnt_sum >= {1'b0, amount};
   assign nre_sum    = nre + 16'd2;
   assign nre_wrap   = (nre_sum == rate);

   assign IQ_FIFO_Read_Enable    = fire && (half || last_beat);
   assign Noise_FIFO_Read_Enable = fire && ((nre_wrap && (nlane == LANE_IDX_W'(LANES-1))) || last_beat);

   upd_slow_lane_mux u_mux_re0_i (.word(IQ_Data_SUM),    .sel({half, 2'd0}), .lane(re0_i));
   upd_slow_lane_mux u_mux_re0_q (.word(IQ_Data_SUM),    .sel({half, 2'd1}), .lane(re0_q));
   upd_slow_lane_mux u_mux_re1_i (.word(IQ_Data_SUM),    .sel({half, 2'd2}), .lane(re1_i));
   upd_slow_lane_mux u_mux_re1_q (.word(IQ_Data_SUM),    .sel({half, 2'd3}), .lane(re1_q));
   upd_slow_lane_mux u_mux_noise (.word(Noise_Data_SUM), .sel(nlane),        .lane(noise));

   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  state_next = ST_RUN;
         ST_RUN:   if (fire && last_beat) state_next = ST_FLUSH;
         ST_FLUSH: state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   // IDLE re-latches the user parameters so each user starts from half 0, lane 0.
   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         rate   <= '0;
         amount <= '0;
         re_cnt <= '0;
         nre    <= '0;
         half   <= 1'b0;
         nlane  <= '0;
      end else if (state == ST_IDLE) begin
         rate   <= i_user_iq_noise_rate;
         amount <= i_cur_user_re_amounts;
         re_cnt <= '0;
         nre    <= '0;
         half   <= 1'b0;
         nlane  <= '0;
      end else if (fire) begin
         re_cnt <= re_cnt_sum[15:0];
         half   <= ~half;
         if (nre_wrap) begin
            nre   <= '0;
            nlane <= nlane + LANE_IDX_W'(1);
         end else begin
            nre   <= nre_sum;
         end
      end
   end

   always_ff @(posedge i_core_clk) begin
      if (i_rx_rst) begin
         o_data_strobe <= 1'b0;
         o_re0_data_i  <= '0;
         o_re0_data_q  <= '0;
         o_re1_data_i  <= '0;
         o_re1_data_q  <= '0;
         o_noise_data  <= '0;
      end else begin
         o_data_strobe <= fire;
         if (fire) begin
            o_re0_data_i <= re0_i;
            o_re0_data_q <= re0_q;
            o_re1_data_i <= re1_i;
            o_re1_data_q <= re1_q;
            o_noise_data <= noise;
         end
      end
   end

endmodule

// File: tb/tb_upd_slow_phy_to_llr.sv
// Self-checking bench: FIFO model plus an RE-index reference model of the unpacked stream.
module tb_upd_slow_phy_to_llr;

   localparam int DEPTH = 8192;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [15:0]  rate_in = 16'd2;
   logic [15:0]  amount_in = 16'd2;
   logic [127:0] iq_head;
   logic [127:0] noise_head;
   logic         iq_empty;
   logic         noise_empty;
   logic         iq_rd;
   logic         n_rd;
   logic         strobe;
   logic [15:0]  re0_i, re0_q, re1_i, re1_q, noise_out;

   logic [127:0] iq_mem [DEPTH];
   logic [127:0] n_mem  [DEPTH];
   int           iq_ptr = 0;
   int           n_ptr  = 0;
   logic         iq_block = 1'b1;
   logic         n_block  = 1'b1;

   int checks = 0;
   int passes = 0;

   int cur_rate   = 2;
   int cur_amount = 2;
   int mon_b      = 0;
   int iq_base    = 0;
   int n_base     = 0;
   int users_done = 0;
   int strobes    = 0;
   int mon_v;
   int mon_h;
   logic [127:0] mon_w;
   logic [127:0] mon_nw;
   logic [79:0]  mon_exp;

   always #5 clk = ~clk;

   upd_slow_phy_to_llr dut (
      .i_core_clk             (clk),
      .i_rx_rst               (rst),
      .i_user_iq_noise_rate   (rate_in),
      .i_cur_user_re_amounts  (amount_in),
      .IQ_Data_SUM            (iq_head),
      .Noise_Data_SUM         (noise_head),
      .IQ_FIFO_Empty          (iq_empty),
      .Noise_FIFO_Empty       (noise_empty),
      .IQ_FIFO_Read_Enable    (iq_rd),
      .Noise_FIFO_Read_Enable (n_rd),
      .o_data_strobe          (strobe),
      .o_re0_data_i           (re0_i),
      .o_re0_data_q           (re0_q),
      .o_re1_data_i           (re1_i),
      .o_re1_data_q           (re1_q),
      .o_noise_data           (noise_out)
   );

   // First-word-fall-through FIFO model: head is the word at the read pointer.
   assign iq_head     = iq_mem[iq_ptr % DEPTH];
   assign noise_head  = n_mem[n_ptr % DEPTH];
   assign iq_empty    = iq_block;
   assign noise_empty = n_block;

   always @(posedge clk) begin
      if (iq_rd) iq_ptr <= iq_ptr + 1;
      if (n_rd)  n_ptr  <= n_ptr + 1;
   end

   task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Reference model: RE r uses IQ word r/4 of the user, noise value r/rate, packed 8 per noise word.
   always @(negedge clk) begin
      if (rst) begin
         mon_b   = 0;
         iq_base = iq_ptr;
         n_base  = n_ptr;
         checkOutput("rd_en_in_reset", {78'd0, iq_rd, n_rd}, 80'd0);
      end else if (strobe) begin
         strobes++;
         mon_v  = (2 * mon_b) / cur_rate;
         mon_h  = mon_b % 2;
         mon_w  = iq_mem[(iq_base + mon_b / 2) % DEPTH];
         mon_nw = n_mem[(n_base + mon_v / 8) % DEPTH];
         mon_exp = {mon_w[64*mon_h +: 16], mon_w[64*mon_h+16 +: 16],
                    mon_w[64*mon_h+32 +: 16], mon_w[64*mon_h+48 +: 16],
                    mon_nw[16*(mon_v % 8) +: 16]};
         checkOutput($sformatf("beat%0d", mon_b),
                     {re0_i, re0_q, re1_i, re1_q, noise_out}, mon_exp);
         mon_b++;
         if (2 * mon_b >= cur_amount) begin
            iq_base    = iq_base + (mon_b + 1) / 2;
            n_base     = n_base + mon_v / 8 + 1;
            mon_b      = 0;
            users_done++;
         end
      end
   end

   typedef struct {
      int rate;
      int amount;
      int exp_beats;
      int exp_iq;
      int exp_noise;
      bit const_data;
      bit stalls;
   } case_t;

   case_t cases [5];

   task automatic applyStimulus(input int rate, input int amount, input bit const_data);
      @(posedge clk); #1;
      rst      = 1'b1;
      iq_block = 1'b1;
      n_block  = 1'b1;
      rate_in   = 16'(rate);
      amount_in = 16'(amount);
      cur_rate   = rate;
      cur_amount = amount;
      @(posedge clk); #1;
      for (int i = 0; i < 1100; i++) begin
         if (const_data) begin
            iq_mem[(iq_ptr + i) % DEPTH] = 128'h0077_0066_0055_0044_0033_0022_0011_000C;
            n_mem[(n_ptr + i) % DEPTH]   = 128'h0077_0066_0055_0044_0033_0022_0011_000C;
         end else begin
            iq_mem[(iq_ptr + i) % DEPTH] = {$urandom, $urandom, $urandom, $urandom};
            n_mem[(n_ptr + i) % DEPTH]   = {$urandom, $urandom, $urandom, $urandom};
         end
      end
      @(posedge clk); #1;
      checkOutput("reset_outputs", {strobe, re0_i, re0_q, re1_i, re1_q}, 80'd0);
      rst      = 1'b0;
      iq_block = 1'b0;
      n_block  = 1'b0;
   endtask

   task automatic waitUsers(input int target, input string name);
      for (int c = 0; c < 4000 && users_done < target; c++) begin
         @(negedge clk); #1;
      end
      if (users_done < target) checkOutput({"timeout_", name}, 80'(users_done), 80'(target));
   endtask

   task automatic waitBeats(input int n);
      for (int c = 0; c < 2000 && mon_b < n; c++) begin
         @(negedge clk); #1;
      end
      if (mon_b < n) checkOutput("timeout_beats", 80'(mon_b), 80'(n));
   endtask

   task automatic stallFifo(input bit iq_side, input int cycles);
      @(posedge clk); #1;
      if (iq_side) iq_block = 1'b1;
      else         n_block  = 1'b1;
      @(posedge clk);
      repeat (cycles) begin
         @(negedge clk);
         checkOutput(iq_side ? "iq_stall" : "noise_stall", {77'd0, strobe, iq_rd, n_rd}, 80'd0);
      end
      @(posedge clk); #1;
      iq_block = 1'b0;
      n_block  = 1'b0;
   endtask

   int u0, s0, iq0, n0, iq_snap, n_snap;

   initial begin
      cases[0] = '{8,  1800, 900, 450, 29, 1'b1, 1'b1};
      cases[1] = '{2,  6,    3,   2,   1,  1'b0, 1'b0};
      cases[2] = '{2,  40,   20,  10,  3,  1'b0, 1'b0};
      cases[3] = '{16, 256,  128, 64,  2,  1'b0, 1'b0};
      cases[4] = '{4,  20,   10,  5,   1,  1'b0, 1'b0};

      for (int k = 0; k < 5; k++) begin
         applyStimulus(cases[k].rate, cases[k].amount, cases[k].const_data);
         u0  = users_done;
         s0  = strobes;
         iq0 = iq_ptr;
         n0  = n_ptr;
         if (cases[k].stalls) begin
            waitBeats(100);
            stallFifo(1'b1, 39);
            waitBeats(200);
            stallFifo(1'b0, 25);
         end
         waitUsers(u0 + 1, $sformatf("case%0d", k));
         checkOutput($sformatf("case%0d_strobes", k), 80'(strobes - s0), 80'(cases[k].exp_beats));
         checkOutput($sformatf("case%0d_iq_pops", k), 80'(iq_ptr - iq0), 80'(cases[k].exp_iq));
         checkOutput($sformatf("case%0d_noise_pops", k), 80'(n_ptr - n0), 80'(cases[k].exp_noise));
         // The following user must restart at half 0, lane 0 after FLUSH.
         if (cases[k].const_data) waitBeats(4);
      end

      // Reset in the middle of a user: no pops, outputs cleared, then a clean restart.
      applyStimulus(4, 40, 1'b0);
      waitBeats(5);
      @(posedge clk); #1;
      rst = 1'b1;
      iq_snap = iq_ptr;
      n_snap  = n_ptr;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midreset_outputs", {strobe, re0_i, re0_q, re1_i, re1_q}, 80'd0);
      checkOutput("midreset_noise", {64'd0, noise_out}, 80'd0);
      repeat (2) @(posedge clk);
      #1;
      checkOutput("midreset_no_pops", {16'd0, 32'(iq_ptr - iq_snap), 32'(n_ptr - n_snap)}, 80'd0);
      rst = 1'b0;
      u0  = users_done;
      s0  = strobes;
      iq0 = iq_ptr;
      n0  = n_ptr;
      waitUsers(u0 + 1, "after_reset");
      checkOutput("after_reset_strobes", 80'(strobes - s0), 80'd20);
      checkOutput("after_reset_iq_pops", 80'(iq_ptr - iq0), 80'd10);
      checkOutput("after_reset_noise_pops", 80'(n_ptr - n0), 80'd2);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
